// File: rtl/fp_dot_product_sequencer.sv
// Dot-product host sequencer: issues rows of M against a held x to the vector ALU and
// collects results in a FWFT FIFO under credit flow control. Optional protocol checker: FP_DOT_PRODUCT_SEQUENCER_CHECK_EN.
`timescale 1ns/1ps
module fp_dot_product_sequencer #(
  parameter int WIDTH       = 32,
  parameter int NUM_INPUTS  = 7,
  parameter int ALU_LATENCY = 20,
  parameter int FIFO_DEPTH  = 8,
  parameter int ROWS_W      = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load_x,
  input  logic [WIDTH*NUM_INPUTS-1:0]     x_in,
  input  logic                            start,
  input  logic [ROWS_W-1:0]               num_rows,
  input  logic                            row_valid,
  output logic                            row_ready,
  input  logic [WIDTH*NUM_INPUTS-1:0]     row_b,
  input  logic [WIDTH-1:0]                row_c,
  input  logic [$clog2(NUM_INPUTS+1)-1:0] row_len,
  output logic [WIDTH*NUM_INPUTS-1:0]     alu_a,
  output logic [WIDTH*NUM_INPUTS-1:0]     alu_b,
  output logic [WIDTH-1:0]                alu_c,
  output logic [NUM_INPUTS-1:0]           alu_enable,
  output logic                            alu_ready,
  output logic                            alu_dot_product_mode,
  input  logic [WIDTH-1:0]                alu_dot_product_out,
  input  logic                            alu_dot_product_valid,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [WIDTH-1:0]                res_data,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  if (ALU_LATENCY < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0) begin : g_bad_params
    $error("fp_dot_product_sequencer: FIFO_DEPTH must be a power of two >= 2 and ALU_LATENCY >= 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} state_t;
  state_t state, next;

  logic [WIDTH*NUM_INPUTS-1:0] x_reg;
  logic [ROWS_W-1:0]           num_rows_q, issued, popped;
  logic [CW-1:0]               credits;
  logic [PW:0]                 wr_ptr, rd_ptr;
  logic [WIDTH-1:0]            mem [FIFO_DEPTH];
  logic [NUM_INPUTS-1:0]       row_mask;
  logic                        accept, pop, push, empty;

  assign accept    = row_valid && row_ready;
  assign pop       = res_valid && res_ready;
  // Results arriving while IDLE belong to a job killed by reset and are dropped.
  assign push      = alu_dot_product_valid && (state != IDLE);
  assign empty     = (wr_ptr == rd_ptr);
  assign res_valid = !empty;
  assign res_data  = empty ? '0 : mem[rd_ptr[PW-1:0]];
  assign alu_a     = x_reg;

  always_comb begin
    row_mask = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) row_mask[i] = (i < 32'(row_len));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start) next = (num_rows == '0) ? DONE : BUSY;
      BUSY:    if (issued == num_rows_q) next = DRAIN;
      DRAIN:   if (popped == num_rows_q) next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    row_ready            = 1'b0;
    busy                 = (state != IDLE);
    done                 = (state == DONE);
    alu_dot_product_mode = (state == BUSY) || (state == DRAIN);
    if (state == BUSY) row_ready = (credits != '0) && (issued < num_rows_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg      <= '0;
      num_rows_q <= '0;
      issued     <= '0;
      popped     <= '0;
      credits    <= CW'(FIFO_DEPTH);
      alu_ready  <= 1'b0;
      alu_b      <= '0;
      alu_c      <= '0;
      alu_enable <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      if (state == IDLE && load_x) x_reg <= x_in;
      if (state == IDLE && start) begin
        num_rows_q <= num_rows;
        issued     <= '0;
        popped     <= '0;
      end else begin
        if (accept) issued <= issued + ROWS_W'(1);
        if (pop)    popped <= popped + ROWS_W'(1);
      end
      alu_ready <= accept;
      if (accept) begin
        alu_b      <= row_b;
        alu_c      <= row_c;
        alu_enable <= row_mask;
      end
      // A credit is a FIFO slot not yet owned by an issued row or a held result.
      if (accept && !pop)      credits <= credits - CW'(1);
      else if (pop && !accept) credits <= credits + CW'(1);
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= alu_dot_product_out;
  end

`ifdef FP_DOT_PRODUCT_SEQUENCER_CHECK_EN
  localparam int AGE_LIMIT = 2*ALU_LATENCY;
  localparam int AW        = $clog2(AGE_LIMIT+2);
  logic [CW-1:0] outstanding;
  logic [AW-1:0] age;

  // Age is measured since the last result (or first issue), a lower bound on head-of-line age.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      age         <= '0;
      err         <= 1'b0;
    end else begin
      case ({alu_ready, alu_dot_product_valid && (outstanding != '0)})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      if (outstanding == '0 || alu_dot_product_valid) age <= '0;
      else if (age <= AW'(AGE_LIMIT))                 age <= age + AW'(1);
      if ((alu_dot_product_valid && outstanding == '0) || age > AW'(AGE_LIMIT)) err <= 1'b1;
    end
  end
`else
  always_comb err = 1'b0;
`endif

endmodule

// File: tb/tb_fp_dot_product_sequencer.sv
// Self-checking bench for fp_dot_product_sequencer with a behavioural latency-L ALU and real-valued reference.
`timescale 1ns/1ps
module tb_fp_dot_product_sequencer;
  localparam int W = 32, N = 7, L = 20, D = 8, RW = 16;

  logic             clk = 1'b0;
  logic             rst, load_x, start, row_valid, row_ready, res_valid, res_ready;
  logic [W*N-1:0]   x_in, row_b, alu_a, alu_b;
  logic [RW-1:0]    num_rows;
  logic [W-1:0]     row_c, alu_c, alu_dot_product_out, res_data;
  logic [2:0]       row_len;
  logic [N-1:0]     alu_enable;
  logic             alu_ready, alu_dot_product_mode, alu_dot_product_valid, busy, done, err;

  always #5 clk = ~clk;

  fp_dot_product_sequencer #(.WIDTH(W), .NUM_INPUTS(N), .ALU_LATENCY(L), .FIFO_DEPTH(D), .ROWS_W(RW)) dut (
    .clk(clk), .rst(rst), .load_x(load_x), .x_in(x_in), .start(start), .num_rows(num_rows),
    .row_valid(row_valid), .row_ready(row_ready), .row_b(row_b), .row_c(row_c), .row_len(row_len),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_enable(alu_enable), .alu_ready(alu_ready),
    .alu_dot_product_mode(alu_dot_product_mode), .alu_dot_product_out(alu_dot_product_out),
    .alu_dot_product_valid(alu_dot_product_valid), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy), .done(done), .err(err));

  int vectors = 0, miscompares = 0;

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d; logic [10:0] e; logic [30:0] em;
    d = $realtobits(r);
    if (d[62:0] == '0) return 32'h0;
    e  = d[62:52] - 11'd896;
    em = {e[7:0], d[51:29]} + 31'(d[28]);
    return {d[63], em};
  endfunction

  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:0] == '0) return 0.0;
    e = 11'(f[30:23]) + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'b0});
  endfunction

  function automatic real rabs(input real r);
    return (r < 0.0) ? -r : r;
  endfunction

  // Behavioural ALU: sum of enabled a_i*b_i plus c, delivered L cycles after issue.
  logic        pv [0:L] = '{default: 1'b0};
  logic [31:0] pd [0:L] = '{default: '0};
  logic        inject = 1'b0;
  always @(negedge clk) begin
    real s;
    for (int i = L; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; end
    s = f2r(alu_c);
    for (int i = 0; i < N; i++)
      if (alu_enable[i]) s = s + f2r(alu_a[i*W +: W]) * f2r(alu_b[i*W +: W]);
    pv[0] = alu_ready;
    pd[0] = r2f(s);
    alu_dot_product_valid = pv[L] | inject;
    alu_dot_product_out   = pd[L];
  end

  logic [31:0]  got [$];
  int           acc_cnt = 0, issue_cnt = 0, done_cnt = 0, rv_cnt = 0;
  logic [N-1:0] last_en = '0;
  always @(posedge clk) begin
    if (row_valid && row_ready) acc_cnt++;
    if (alu_ready) begin issue_cnt++; last_en = alu_enable; end
    if (done) done_cnt++;
    if (res_valid) rv_cnt++;
    if (res_valid && res_ready) got.push_back(res_data);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_real(input string tag, input real obs, input real exp, input real tol);
    logic ok;
    vectors++;
    ok = (rabs(obs - exp) <= tol);
    assert (ok === 1'b1) else begin
      miscompares++;
      $error("FAIL %s: observed %f expected %f", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] got_at(input int idx);
    return (got.size() > idx) ? got[idx] : 32'hffffffff;
  endfunction

  function automatic logic [W*N-1:0] vec_x();
    logic [W*N-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = r2f(0.1 * (i + 1));
    return v;
  endfunction

  function automatic logic [W*N-1:0] vec_b();
    logic [W*N-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = r2f(0.8 + 0.1 * i);
    return v;
  endfunction

  task automatic start_job(input int nr);
    num_rows = RW'(nr); start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_row(input logic [W*N-1:0] b, input logic [31:0] c, input int len, input bit rand_rr);
    int n; logic rdy;
    row_b = b; row_c = c; row_len = 3'(len); row_valid = 1'b1;
    for (n = 0; n < 300; n++) begin
      rdy = row_ready;
      if (rand_rr) res_ready = 1'($urandom_range(0, 1));
      step();
      if (rdy) break;
    end
    row_valid = 1'b0;
    if (n >= 300) check("row_accept_timeout", 256'(n), 256'(0));
  endtask

  task automatic wait_done(input string tag);
    int n;
    for (n = 0; n < 2000; n++) begin
      step();
      if (done) break;
    end
    check({tag, "_done_seen"}, 256'(n < 2000), 256'(1));
    step();
    check({tag, "_busy_after_done"}, 256'(busy), 256'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, 256'({row_ready, alu_ready, alu_dot_product_mode, res_valid, busy, done, err}), 256'(0));
    check({tag, "_alu_enable"}, 256'(alu_enable), 256'(0));
    check({tag, "_alu_b"}, 256'(alu_b), 256'(0));
    check({tag, "_alu_c"}, 256'(alu_c), 256'(0));
    check({tag, "_res_data"}, 256'(res_data), 256'(0));
    check({tag, "_alu_a"}, 256'(alu_a), 256'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gb, ab, ib, db, rb;
    logic [W*N-1:0] xv, bv;
    real xr [N];
    real exp_q [$];

    rst = 1'b1; load_x = 1'b0; x_in = '0; start = 1'b0; num_rows = '0; row_valid = 1'b0;
    row_b = '0; row_c = '0; row_len = '0; res_ready = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    load_x = 1'b1; x_in = vec_x();
    step();
    load_x = 1'b0; x_in = '0;
    check("x_loaded", 256'(alu_a), 256'(vec_x()));

    // Single full-length row
    gb = got.size(); db = done_cnt;
    start_job(1);
    send_row(vec_b(), 32'h0, 7, 1'b0);
    wait_done("single");
    check("single_count", 256'(got.size() - gb), 256'(1));
    check_real("single_result", f2r(got_at(gb)), 3.36, 1e-5);
    check("single_done_once", 256'(done_cnt - db), 256'(1));

    // Lane mask with row_len = 2, then row_len = 0
    gb = got.size();
    start_job(1);
    send_row(vec_b(), r2f(1.0), 2, 1'b0);
    wait_done("len2");
    check("len2_enable", 256'(last_en), 256'(7'b0000011));
    check_real("len2_result", f2r(got_at(gb)), 1.26, 1e-5);
    gb = got.size();
    start_job(1);
    send_row(vec_b(), r2f(1.0), 0, 1'b0);
    wait_done("len0");
    check("len0_enable", 256'(last_en), 256'(0));
    check("len0_result", 256'(got_at(gb)), 256'(r2f(1.0)));

    // Backpressure: only FIFO_DEPTH rows may be in flight while results are not consumed
    res_ready = 1'b0; gb = got.size(); ab = acc_cnt;
    start_job(20);
    for (int k = 0; k < 8; k++) send_row(vec_b(), r2f(real'(k)), 7, 1'b0);
    repeat (40) step();
    check("bp_accepted", 256'(acc_cnt - ab), 256'(8));
    check("bp_row_ready_low", 256'(row_ready), 256'(0));
    check("bp_res_valid", 256'(res_valid), 256'(1));
    res_ready = 1'b1;
    for (int k = 8; k < 20; k++) send_row(vec_b(), r2f(real'(k)), 7, 1'b0);
    wait_done("bp");
    check("bp_count", 256'(got.size() - gb), 256'(20));
    for (int k = 0; k < 20; k++)
      check_real($sformatf("bp_result_%0d", k), f2r(got_at(gb + k)), 3.36 + k, 1e-4);

    // Zero-row job
    ib = issue_cnt; db = done_cnt;
    start_job(0);
    check("zero_done_pulse", 256'(done), 256'(1));
    step();
    check("zero_done_low", 256'({done, busy}), 256'(0));
    repeat (3) step();
    check("zero_no_issue", 256'(issue_cnt - ib), 256'(0));
    check("zero_done_once", 256'(done_cnt - db), 256'(1));

    // Reset in DRAIN with three results still inside the ALU
    res_ready = 1'b0;
    start_job(3);
    for (int k = 0; k < 3; k++) send_row(vec_b(), r2f(real'(k)), 7, 1'b0);
    step(); step();
    check("drain_state", 256'({row_ready, busy, alu_dot_product_mode}), 256'(3'b011));
    rst = 1'b1; #1;
    check_reset_outputs("midrst");
    step();
    rst = 1'b0; res_ready = 1'b1; rb = rv_cnt;
    repeat (30) step();
    check("midrst_no_res_valid", 256'(rv_cnt - rb), 256'(0));
    check("midrst_idle", 256'(busy), 256'(0));
`ifndef FP_DOT_PRODUCT_SEQUENCER_CHECK_EN
    check("midrst_err", 256'(err), 256'(0));
`endif

    // Randomized job with random row gaps and random consumer stalls
    for (int i = 0; i < N; i++) begin
      xr[i] = f2r(r2f(real'(int'($urandom_range(0, 4000)) - 2000) / 1000.0));
      xv[i*W +: W] = r2f(xr[i]);
    end
    load_x = 1'b1; x_in = xv;
    step();
    load_x = 1'b0;
    gb = got.size();
    start_job(12);
    for (int k = 0; k < 12; k++) begin
      int len; real c, e;
      len = int'($urandom_range(0, 7));
      c = f2r(r2f(real'(int'($urandom_range(0, 4000)) - 2000) / 1000.0));
      e = c;
      for (int i = 0; i < N; i++) begin
        real bi;
        bi = f2r(r2f(real'(int'($urandom_range(0, 4000)) - 2000) / 1000.0));
        bv[i*W +: W] = r2f(bi);
        if (i < len) e = e + xr[i] * bi;
      end
      exp_q.push_back(e);
      repeat ($urandom_range(0, 2)) step();
      send_row(bv, r2f(c), len, 1'b1);
    end
    res_ready = 1'b1;
    wait_done("rand");
    check("rand_count", 256'(got.size() - gb), 256'(12));
    for (int k = 0; k < 12; k++)
      check_real($sformatf("rand_result_%0d", k), f2r(got_at(gb + k)), exp_q[k], 1e-4 * (1.0 + rabs(exp_q[k])));

    // Spurious ALU result while IDLE
    rb = rv_cnt;
    inject = 1'b1;
    step();
    inject = 1'b0;
    step(); step();
    check("spurious_no_res_valid", 256'(rv_cnt - rb), 256'(0));
`ifdef FP_DOT_PRODUCT_SEQUENCER_CHECK_EN
    check("spurious_err_set", 256'(err), 256'(1));
    repeat (5) step();
    check("spurious_err_sticky", 256'(err), 256'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("spurious_err_cleared", 256'(err), 256'(0));
`else
    check("spurious_err_tied", 256'(err), 256'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
